// File: rtl/xcorr_pkg.sv
// Shared types and width helpers for the xcorr_multi cross-correlation engine.
//   xcorr_state_t : run-sequencer states
//   acc_width     : signed accumulator width for a given sample width / window
//   lag_width     : width of a lag index covering -max_lag..+max_lag
//   ch_width      : width of a channel index (at least 1)
package xcorr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        WRITE,
        DONE
    } xcorr_state_t;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned win);
        return 2 * dw + $clog2(win);
    endfunction

    function automatic int unsigned lag_width(input int unsigned max_lag);
        return $clog2(2 * max_lag + 1);
    endfunction

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/xcorr_mac.sv
// Signed multiply-accumulate stage with a 2-deep valid pipeline.
// en marks a cycle in which RAM addresses are issued; a/b return one cycle
// later, the product is registered, and it is added one cycle after that.
// Ports:
//   clk, rst  : clock, async active-high reset
//   en        : address issued this cycle
//   clr       : clear accumulator (has priority over accumulate)
//   a, b      : signed samples returning from the RAMs
//   sum_c     : accumulator value including any product landing this cycle
module xcorr_mac #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_W      = 19
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_W-1:0]      sum_c
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic                     d_v;
    logic                     p_v;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    // Next accumulator value; sign extension comes from the signed cast.
    assign sum_c = p_v ? (acc + ACC_W'(prod)) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_v  <= 1'b0;
            p_v  <= 1'b0;
            prod <= '0;
            acc  <= '0;
        end else begin
            d_v <= en;
            p_v <= d_v;
            if (d_v) begin
                prod <= PROD_W'(a) * PROD_W'(b);
            end
            if (clr) begin
                acc <= '0;
            end else if (p_v) begin
                acc <= sum_c;
            end
        end
    end

endmodule

// File: rtl/xcorr_multi.sv
// Multi-channel lag-windowed cross-correlation engine.
// After start, correlates the reference buffer against each channel buffer
// for lags -MAX_LAG..+MAX_LAG (channel outer, lag inner) and streams one
// signed sum per (channel, lag). Optional peak reporting under XCORR_PEAK_EN;
// without it the pk_* ports are tied to zero.
// Ports:
//   clk, rst            : clock, async active-high reset
//   start               : launch a run (sampled in IDLE only)
//   ref_addr/ref_data   : reference RAM read port (1-cycle latency)
//   ch_sel/ch_addr/ch_data : channel RAM read port (1-cycle latency)
//   s_ch/s_lag_idx/s_data/s_valid : result write strobe
//   pk_ch/pk_lag/pk_val/pk_valid  : per-channel peak report
//   busy, done          : run in progress / end-of-run pulse
module xcorr_multi
    import xcorr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WIN_LEN    = 256,
    parameter int unsigned MAX_LAG    = 127,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    output logic [ADDR_WIDTH-1:0]                             ref_addr,
    input  logic [DATA_WIDTH-1:0]                             ref_data,
    output logic [ch_width(NUM_CH)-1:0]                       ch_sel,
    output logic [ADDR_WIDTH-1:0]                             ch_addr,
    input  logic [DATA_WIDTH-1:0]                             ch_data,
    output logic [ch_width(NUM_CH)-1:0]                       s_ch,
    output logic [lag_width(MAX_LAG)-1:0]                     s_lag_idx,
    output logic signed [acc_width(DATA_WIDTH, WIN_LEN)-1:0]  s_data,
    output logic                                              s_valid,
    output logic [ch_width(NUM_CH)-1:0]                       pk_ch,
    output logic signed [lag_width(MAX_LAG):0]                pk_lag,
    output logic signed [acc_width(DATA_WIDTH, WIN_LEN)-1:0]  pk_val,
    output logic                                              pk_valid,
    output logic                                              busy,
    output logic                                              done
);

    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned LAG_W = lag_width(MAX_LAG);
    localparam int unsigned ACC_W = acc_width(DATA_WIDTH, WIN_LEN);

    localparam logic [ADDR_WIDTH-1:0] REF_FIRST = ADDR_WIDTH'(MAX_LAG);
    localparam logic [ADDR_WIDTH-1:0] REF_LAST  = ADDR_WIDTH'(MAX_LAG + WIN_LEN - 1);
    localparam logic [LAG_W-1:0]      LAG_LAST  = LAG_W'(2 * MAX_LAG);
    localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(NUM_CH - 1);

    // Every channel address MAX_LAG+i+k must stay inside the buffer.
    if (WIN_LEN + 2 * MAX_LAG > 2 ** ADDR_WIDTH) begin : g_bad_cfg
        $error("xcorr_multi: WIN_LEN + 2*MAX_LAG exceeds the buffer size");
    end

    xcorr_state_t            state;
    logic [LAG_W-1:0]        lag_idx;
    logic                    drain_cnt;
    logic                    mac_en_c;
    logic                    mac_clr_c;
    logic signed [ACC_W-1:0] sum_c;

    assign mac_en_c  = (state == ACCUM);
    assign mac_clr_c = (state == WRITE) || (state == IDLE);

    xcorr_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en_c),
        .clr   (mac_clr_c),
        .a     (ref_data),
        .b     (ch_data),
        .sum_c (sum_c)
    );

    // Run sequencer; ch_sel doubles as the channel loop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ref_addr  <= '0;
            ch_addr   <= '0;
            ch_sel    <= '0;
            lag_idx   <= '0;
            drain_cnt <= 1'b0;
            s_ch      <= '0;
            s_lag_idx <= '0;
            s_data    <= '0;
            s_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            s_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        busy     <= 1'b1;
                        ch_sel   <= '0;
                        lag_idx  <= '0;
                        ref_addr <= REF_FIRST;
                        ch_addr  <= '0;
                    end
                end
                ACCUM: begin
                    if (ref_addr == REF_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        ref_addr <= ref_addr + ADDR_WIDTH'(1);
                        ch_addr  <= ch_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Last product lands on the second drain edge; capture it via sum_c.
                    if (drain_cnt) begin
                        state     <= WRITE;
                        s_valid   <= 1'b1;
                        s_data    <= sum_c;
                        s_ch      <= ch_sel;
                        s_lag_idx <= lag_idx;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                WRITE: begin
                    state    <= ACCUM;
                    ref_addr <= REF_FIRST;
                    if (lag_idx != LAG_LAST) begin
                        lag_idx <= lag_idx + LAG_W'(1);
                        ch_addr <= ADDR_WIDTH'(lag_idx) + ADDR_WIDTH'(1);
                    end else if (ch_sel != CH_LAST) begin
                        lag_idx <= '0;
                        ch_sel  <= ch_sel + CH_W'(1);
                        ch_addr <= '0;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef XCORR_PEAK_EN
    logic signed [ACC_W-1:0] run_max;
    logic signed [LAG_W:0]   run_lag;
    logic signed [LAG_W:0]   cur_lag_c;
    logic                    take_c;

    assign cur_lag_c = $signed({1'b0, s_lag_idx}) - $signed((LAG_W + 1)'(MAX_LAG));
    // First lag of a channel always seeds; afterwards only a strictly larger sum wins.
    assign take_c    = (s_lag_idx == '0) || (s_data > run_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max  <= '0;
            run_lag  <= '0;
            pk_ch    <= '0;
            pk_lag   <= '0;
            pk_val   <= '0;
            pk_valid <= 1'b0;
        end else begin
            pk_valid <= 1'b0;
            if (s_valid) begin
                if (take_c) begin
                    run_max <= s_data;
                    run_lag <= cur_lag_c;
                end
                if (s_lag_idx == LAG_LAST) begin
                    pk_valid <= 1'b1;
                    pk_ch    <= s_ch;
                    pk_val   <= take_c ? s_data : run_max;
                    pk_lag   <= take_c ? cur_lag_c : run_lag;
                end
            end
        end
    end
`else
    assign pk_ch    = '0;
    assign pk_lag   = '0;
    assign pk_val   = '0;
    assign pk_valid = 1'b0;
`endif

endmodule

// File: tb/tb_xcorr_multi.sv
// Scoreboard bench for xcorr_multi (ADDR_WIDTH=5, DATA_WIDTH=8, WIN_LEN=8,
// MAX_LAG=4, NUM_CH=2). Expected sums come from a direct dot-product model
// of the RAM contents, or from hand-computed constants.
module tb_xcorr_multi;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned WL    = 8;
    localparam int unsigned ML    = 4;
    localparam int unsigned NCH   = 2;
    localparam int unsigned CH_W  = 1;
    localparam int unsigned LAG_W = 4;
    localparam int unsigned ACC_W = 19;
    localparam int          NLAG  = 9;
    localparam int          LCYC  = 11;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [AW-1:0]           ref_addr;
    logic [DW-1:0]           ref_data;
    logic [CH_W-1:0]         ch_sel;
    logic [AW-1:0]           ch_addr;
    logic [DW-1:0]           ch_data;
    logic [CH_W-1:0]         s_ch;
    logic [LAG_W-1:0]        s_lag_idx;
    logic signed [ACC_W-1:0] s_data;
    logic                    s_valid;
    logic [CH_W-1:0]         pk_ch;
    logic signed [LAG_W:0]   pk_lag;
    logic signed [ACC_W-1:0] pk_val;
    logic                    pk_valid;
    logic                    busy;
    logic                    done;

    always #5 clk = ~clk;

    xcorr_multi #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WIN_LEN    (WL),
        .MAX_LAG    (ML),
        .NUM_CH     (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_addr  (ref_addr),
        .ref_data  (ref_data),
        .ch_sel    (ch_sel),
        .ch_addr   (ch_addr),
        .ch_data   (ch_data),
        .s_ch      (s_ch),
        .s_lag_idx (s_lag_idx),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .pk_ch     (pk_ch),
        .pk_lag    (pk_lag),
        .pk_val    (pk_val),
        .pk_valid  (pk_valid),
        .busy      (busy),
        .done      (done)
    );

    // Synchronous-read sample RAMs.
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] ch_mem  [2][32];

    always @(posedge clk) begin
        ref_data <= ref_mem[ref_addr];
        ch_data  <= ch_mem[ch_sel][ch_addr];
    end

    typedef struct {
        int ch;
        int lag_idx;
        int data;
    } res_t;

    typedef struct {
        int ch;
        int lag;
        int val;
    } pk_t;

    res_t exp_q[$];
    pk_t  pk_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   pk_nonzero = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Pattern generators: 0 ramp, 1 all -128, 2 all zero, 3 two-pulse.
    function automatic int ref_val(input int p, input int n);
        case (p)
            0:       return n - 8;
            1:       return -128;
            3:       return (n == 8) ? 100 : ((n == 10) ? -50 : 0);
            default: return 0;
        endcase
    endfunction

    function automatic int ch_val(input int p, input int c, input int n);
        if (p == 1) return -128;
        if (p == 2) return 0;
        return (c == 0) ? ref_val(p, n - 2) : ref_val(p, n + 3);
    endfunction

    task automatic load(input int p);
        for (int n = 0; n < 32; n++) begin
            ref_mem[n]   = DW'(ref_val(p, n));
            ch_mem[0][n] = DW'(ch_val(p, 0, n));
            ch_mem[1][n] = DW'(ch_val(p, 1, n));
        end
    endtask

    function automatic int model_sum(input int c, input int k);
        int s = 0;
        for (int i = 0; i < int'(WL); i++) begin
            s += int'($signed(ref_mem[int'(ML) + i])) * int'($signed(ch_mem[c][int'(ML) + i + k]));
        end
        return s;
    endfunction

    // Queue the first 'limit' results in loop order; peaks only for full runs.
    task automatic push_run(input bit use_const, input int const_val, input int limit);
        int   cnt = 0;
        res_t r;
        pk_t  pk;
        for (int c = 0; c < int'(NCH); c++) begin
            int best = 0;
            int best_k = 0;
            for (int li = 0; li < NLAG; li++) begin
                int k = li - int'(ML);
                int v = use_const ? const_val : model_sum(c, k);
                if (li == 0 || v > best) begin
                    best   = v;
                    best_k = k;
                end
                if (cnt < limit) begin
                    r.ch = c; r.lag_idx = li; r.data = v;
                    exp_q.push_back(r);
                end
                cnt++;
            end
            pk.ch = c; pk.lag = best_k; pk.val = best;
`ifdef XCORR_PEAK_EN
            if (limit >= NLAG * int'(NCH)) pk_q.push_back(pk);
`endif
        end
    endtask

    // Result / peak monitor.
    always @(negedge clk) begin
        if (s_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL s_valid_unexpected actual=ch%0d/lag%0d/%0d required=no strobe",
                         s_ch, s_lag_idx, $signed(s_data));
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("s_ch", longint'(s_ch), e.ch);
                check("s_lag_idx", longint'(s_lag_idx), e.lag_idx);
                check("s_data", longint'($signed(s_data)), e.data);
            end
        end
`ifdef XCORR_PEAK_EN
        if (pk_valid === 1'b1) begin
            if (pk_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pk_valid_unexpected actual=ch%0d/lag%0d required=no strobe",
                         pk_ch, $signed(pk_lag));
            end else begin
                pk_t p;
                p = pk_q.pop_front();
                check("pk_ch", longint'(pk_ch), p.ch);
                check("pk_lag", longint'($signed(pk_lag)), p.lag);
                check("pk_val", longint'($signed(pk_val)), p.val);
            end
        end
`else
        if (pk_valid !== 1'b0 || pk_ch !== '0 || pk_lag !== '0 || pk_val !== '0) pk_nonzero++;
`endif
    end

    // Full run: checks addresses each ACCUM cycle, busy, done timing, drained queues.
    task automatic do_run(input string tag, input int poke_at);
        int done_t   = 0;
        int addr_err = 0;
        int busy_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= 400 && done_t == 0; t++) begin
            int lagn = (t - 1) / LCYC;
            int j    = (t - 1) % LCYC;
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (poke_at != 0 && t == poke_at) start = 1'b1;
            if (poke_at != 0 && t == poke_at + 1) start = 1'b0;
            if (busy !== 1'b1) busy_err++;
            if (j < int'(WL) && lagn < NLAG * int'(NCH)) begin
                if (ref_addr !== AW'(int'(ML) + j) || ch_addr !== AW'((lagn % NLAG) + j) ||
                    ch_sel !== CH_W'(lagn / NLAG)) addr_err++;
            end
            if (done === 1'b1) done_t = t;
        end
        check({tag, "_done_cycle"}, done_t, NLAG * int'(NCH) * LCYC + 1);
        check({tag, "_addr_errors"}, addr_err, 0);
        check({tag, "_busy_errors"}, busy_err, 0);
        @(negedge clk);
        check({tag, "_busy_after"}, longint'(busy), 0);
        check({tag, "_done_pulse"}, longint'(done), 0);
        repeat (2) @(negedge clk);
        check({tag, "_results_left"}, exp_q.size(), 0);
        check({tag, "_peaks_left"}, pk_q.size(), 0);
    endtask

    // Reset mid-ACCUM of ch0 lag -1 (lag index 3, cycles 34..41).
    task automatic abort_run();
        int busy_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= 38; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("abort_ctrl", longint'({busy, done, s_valid, pk_valid, ref_addr, ch_addr, ch_sel}), 0);
        check("abort_res", longint'(|{s_ch, s_lag_idx, s_data, pk_ch, pk_lag, pk_val}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_err++;
        end
        check("abort_idle_busy", busy_err, 0);
        check("abort_results_left", exp_q.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        load(2);
        repeat (2) @(negedge clk);
        check("reset_ctrl", longint'({busy, done, s_valid, pk_valid, ref_addr, ch_addr, ch_sel}), 0);
        check("reset_res", longint'(|{s_ch, s_lag_idx, s_data, pk_ch, pk_lag, pk_val}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", longint'(busy), 0);

        load(0);
        push_run(1'b0, 0, 18);
        do_run("ramp", 0);

        load(3);
        push_run(1'b0, 0, 18);
        do_run("pulse_start_busy", 50);

        load(1);
        push_run(1'b1, 131072, 18);
        do_run("extreme", 0);

        load(0);
        push_run(1'b0, 0, 3);
        abort_run();

        load(2);
        push_run(1'b0, 0, 18);
        do_run("zero_tie", 0);

`ifndef XCORR_PEAK_EN
        check("pk_tied_zero_cycles", pk_nonzero, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
